// File: rtl/axi_id_pool_pkg.sv
// Shared constants and helpers for the multi-requester AXI ID pool.
package axi_id_pool_pkg;

    localparam int ID_WIDTH_DEF = 4;
    localparam int NUM_REQ_DEF  = 2;
    localparam int FFZ_MAX      = 256;
    localparam int PTR_W_DEF    = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef logic [PTR_W_DEF-1:0] rr_ptr_t;

    // A single requester still gets a 1-bit pointer that simply never moves off 0.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest clear bit among the first n bits of map; returns n when all are set.
    function automatic int find_first_zero(input logic [FFZ_MAX-1:0] map, input int n);
        int r;
        r = n;
        for (int i = FFZ_MAX - 1; i >= 0; i--)
            if (i < n && !map[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/axi_id_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer advances past the winner.
module axi_id_rr_arb
    import axi_id_pool_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d;
    int            win, best, off;

    // Distance from the pointer picks the winner, so req is only ever indexed by a constant.
    always_comb begin
        win  = 0;
        best = NUM_REQ;
        off  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
            if (req[i] && off < best) begin
                best = off;
                win  = i;
            end
        end
        gnt   = '0;
        ptr_d = ptr_q;
        if (en && best < NUM_REQ) begin
            for (int i = 0; i < NUM_REQ; i++) gnt[i] = (i == win);
            ptr_d = PW'((win + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_id_pool_mc.sv
// Multi-requester AXI ID pool: round-robin allocation of the lowest free ID, one free per cycle.
module axi_id_pool_mc
    import axi_id_pool_pkg::*;
#(
    parameter int ID_WIDTH = ID_WIDTH_DEF,
    parameter int ID_COUNT = 1 << ID_WIDTH,
    parameter int NUM_REQ  = NUM_REQ_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  alloc_req,
    output logic [NUM_REQ-1:0]  alloc_gnt,
    output logic [ID_WIDTH-1:0] alloc_id,
    input  logic                dealloc_req,
    input  logic [ID_WIDTH-1:0] dealloc_id,
    output logic                dealloc_err,
    output logic [ID_WIDTH:0]   free_count,
    output logic                pool_empty,
    output logic [ID_COUNT-1:0] id_busy
);

    localparam int ID_SPACE = 1 << ID_WIDTH;

    logic [ID_COUNT-1:0] busy_q, busy_d;
    logic [ID_SPACE-1:0] busy_ext;
    logic [NUM_REQ-1:0]  gnt_q, arb_gnt, elig;
    logic [ID_WIDTH-1:0] id_q, id_d, free_id;
    logic [ID_WIDTH:0]   free_q, free_d;
    logic                err_q, err_d, grant, legal;

    // A requester is ignored in its own grant cycle so a late-dropped req cannot win twice.
    assign elig = alloc_req & ~gnt_q;

    axi_id_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (free_q != '0),
        .req   (elig),
        .gnt   (arb_gnt)
    );

    assign grant   = |arb_gnt;
    assign free_id = ID_WIDTH'(find_first_zero(FFZ_MAX'(busy_q), ID_COUNT));
    // IDs at or above ID_COUNT land on zero-extended bits and therefore read as free (illegal).
    assign busy_ext = ID_SPACE'(busy_q);
    assign legal    = dealloc_req && busy_ext[dealloc_id];

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < ID_COUNT; i++) begin
            if (grant && free_id == ID_WIDTH'(i)) busy_d[i] = 1'b1;
            if (legal && dealloc_id == ID_WIDTH'(i)) busy_d[i] = 1'b0;
        end
        id_d   = grant ? free_id : '0;
        err_d  = dealloc_req && !legal;
        free_d = free_q;
        case ({legal, grant})
            2'b10:   free_d = free_q + 1'b1;
            2'b01:   free_d = free_q - 1'b1;
            default: free_d = free_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            gnt_q  <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
            free_q <= (ID_WIDTH+1)'(ID_COUNT);
        end else begin
            busy_q <= busy_d;
            gnt_q  <= arb_gnt;
            id_q   <= id_d;
            err_q  <= err_d;
            free_q <= free_d;
        end
    end

    assign alloc_gnt   = gnt_q;
    assign alloc_id    = id_q;
    assign dealloc_err = err_q;
    assign free_count  = free_q;
    assign pool_empty  = (free_q == '0);
    assign id_busy     = busy_q;

endmodule
